// File: rtl/mvau_weight_loader.sv
// Runtime weight-memory writer for the MVAU: takes an AXI-Stream of SIMD*TW weight words
// and fans them out to the PE weight banks in PE-interleaved order.
module mvau_weight_loader #(
   parameter int unsigned SIMD         = 2,
   parameter int unsigned TW           = 1,
   parameter int unsigned PE           = 2,
   parameter int unsigned WMEM_DEPTH   = 4,
   parameter int unsigned WMEM_ADDR_BW = 4
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    start,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [SIMD*TW-1:0]      s_axis_tdata,
   input  logic                    s_axis_tlast,
   output logic [PE-1:0]           wmem_we,
   output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
   output logic [SIMD*TW-1:0]      wmem_wdata,
   output logic                    busy,
   output logic                    done,
   output logic                    err_len
);

   localparam int unsigned PE_BW = (PE > 1) ? $clog2(PE) : 1;
   localparam logic [PE_BW-1:0]        PE_LAST   = PE_BW'(PE - 1);
   localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]              r_state;
   logic [PE_BW-1:0]        r_pe_cnt;
   logic [WMEM_ADDR_BW-1:0] r_addr_cnt;
   logic [PE-1:0]           r_we;
   logic [WMEM_ADDR_BW-1:0] r_waddr;
   logic [SIMD*TW-1:0]      r_wdata;
   logic                    r_err_len;

   logic w_pe_wrap;
   logic w_final;

   assign w_pe_wrap = (r_pe_cnt == PE_LAST);
   assign w_final   = w_pe_wrap && (r_addr_cnt == ADDR_LAST);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state    <= S_IDLE;
         r_pe_cnt   <= '0;
         r_addr_cnt <= '0;
         r_we       <= '0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_err_len  <= 1'b0;
      end else begin
         r_we <= '0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_LOAD;
                  r_pe_cnt   <= '0;
                  r_addr_cnt <= '0;
                  r_err_len  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (s_axis_tvalid) begin
                  r_we    <= PE'(1) << r_pe_cnt;
                  r_waddr <= r_addr_cnt;
                  r_wdata <= s_axis_tdata;
                  if (w_pe_wrap) begin
                     r_pe_cnt   <= '0;
                     r_addr_cnt <= w_final ? '0 : r_addr_cnt + WMEM_ADDR_BW'(1);
                  end else begin
                     r_pe_cnt <= r_pe_cnt + PE_BW'(1);
                  end
                  // Either a missing tlast on the last beat or an early one ends the load with an error.
                  if (w_final || s_axis_tlast) r_state <= S_DONE;
                  if (w_final != s_axis_tlast) r_err_len <= 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_axis_tready = (r_state == S_LOAD);
   assign busy          = (r_state == S_LOAD);
   assign done          = (r_state == S_DONE);
   assign wmem_we       = r_we;
   assign wmem_waddr    = r_waddr;
   assign wmem_wdata    = r_wdata;
   assign err_len       = r_err_len;

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Self-checking bench for mvau_weight_loader: random weight streams compared against
// the expected PE-interleaved write list derived from beat index arithmetic.
module tb_mvau_weight_loader;

   localparam int unsigned SIMD  = 2;
   localparam int unsigned TW    = 1;
   localparam int unsigned PE    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = SIMD * TW;
   localparam int unsigned TOTAL = PE * DEPTH;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          start;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tlast;
   logic [PE-1:0] wmem_we;
   logic [AW-1:0] wmem_waddr;
   logic [DW-1:0] wmem_wdata;
   logic          busy;
   logic          done;
   logic          err_len;

   mvau_weight_loader #(
      .SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(AW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .start(start),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .wmem_we(wmem_we), .wmem_waddr(wmem_waddr), .wmem_wdata(wmem_wdata),
      .busy(busy), .done(done), .err_len(err_len)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0]   obs_q[$];
   logic [DW-1:0] beat_data[TOTAL];
   int            done_cnt;
   int            done_at;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_checks++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Advance one clock and log any write strobe / done pulse seen after the edge.
   task automatic tick();
      @(posedge aclk);
      #1;
      if (wmem_we !== '0) obs_q.push_back(32'({wmem_we, wmem_waddr, wmem_wdata}));
      if (done === 1'b1) begin
         done_cnt++;
         done_at = obs_q.size();
      end
   endtask

   function automatic logic [31:0] exp_write(input int k);
      logic [PE-1:0] we;
      logic [AW-1:0] addr;
      we   = PE'(1) << (k % PE);
      addr = AW'(k / PE);
      return 32'({we, addr, beat_data[k]});
   endfunction

   task automatic new_data();
      for (int i = 0; i < TOTAL; i++) beat_data[i] = DW'($urandom);
   endtask

   // One load: last_at = beat carrying tlast (-1 for none); toggle inserts idle gaps;
   // poke pulses start in the middle of the load.
   task automatic do_load(input string tag, input int last_at, input bit toggle, input bit poke);
      int n_exp;
      int k;
      int cyc;
      bit valid;
      bit exp_err;
      n_exp   = (last_at >= 0 && last_at < TOTAL) ? last_at + 1 : TOTAL;
      exp_err = (last_at != TOTAL - 1);
      new_data();
      obs_q.delete();
      done_cnt = 0;
      done_at  = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      chk({tag, "_err_clr"}, 32'(err_len), 32'd0);
      k   = 0;
      cyc = 0;
      while (k < n_exp && cyc < 200) begin
         valid = toggle ? (cyc % 2 == 0) : 1'b1;
         s_axis_tvalid = valid;
         s_axis_tdata  = valid ? beat_data[k] : DW'($urandom);
         s_axis_tlast  = valid && (k == last_at);
         start         = poke && (cyc == 3 || cyc == 5);
         chk({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
         tick();
         if (valid) k++;
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      start         = 1'b0;
      chk({tag, "_done_last"}, 32'(done), 32'd1);
      chk({tag, "_tready_drop"}, 32'(s_axis_tready), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(n_exp));
      for (int i = 0; i < n_exp && i < obs_q.size(); i++)
         chk({tag, "_write"}, obs_q[i], exp_write(i));
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_at"}, 32'(done_at), 32'(n_exp));
      chk({tag, "_err_len"}, 32'(err_len), 32'(exp_err));
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      aresetn       = 1'b0;
      start         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      obs_q.delete();
      done_cnt = 0;
      done_at  = -1;
      repeat (3) tick();
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_we", 32'(wmem_we), 32'd0);
      chk("rst_waddr", 32'(wmem_waddr), 32'd0);
      chk("rst_wdata", 32'(wmem_wdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err_len), 32'd0);
      aresetn = 1'b1;
      tick();

      do_load("full", TOTAL - 1, 1'b0, 1'b0);
      do_load("gaps", TOTAL - 1, 1'b1, 1'b0);
      do_load("early", 4, 1'b0, 1'b0);
      do_load("notlast", -1, 1'b0, 1'b0);
      do_load("poke", TOTAL - 1, 1'b0, 1'b1);

      // Reset in the middle of a load after four beats.
      new_data();
      obs_q.delete();
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = beat_data[i];
         tick();
      end
      s_axis_tvalid = 1'b0;
      aresetn = 1'b0;
      tick();
      chk("mid_rst_we", 32'(wmem_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
      aresetn = 1'b1;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      s_axis_tvalid = 1'b0;
      chk("mid_rst_nwrites", 32'(obs_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs_q.size(); i++)
         chk("mid_rst_write", obs_q[i], exp_write(i));
      chk("mid_rst_done", 32'(done_cnt), 32'd0);
      do_load("after_rst", TOTAL - 1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mvau_weight_loader.md
Name: mvau_weight_loader

Overview:
- Runtime writer for the MVAU weight memories.
- Accepts an AXI-Stream of weight words, one SIMD*TW word per beat, and fans them out to PE weight-memory write ports.
- Beats are distributed in PE-interleaved order, then the address advances.
- Sits between the host/DMA weight stream and the per-PE weight memories, which are read by the MVAU datapath. Allows weights to be reloaded without a bitstream rebuild.

Parameters:
SIMD, 2, input channels processed in parallel; word width factor
TW, 1, weight bit width
PE, 2, number of processing elements (number of weight-memory banks)
WMEM_DEPTH, 4, words per bank
WMEM_ADDR_BW, 4, bank address width; requires 2^WMEM_ADDR_BW >= WMEM_DEPTH

Ports:
aclk  in  1  main clock
aresetn  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begins a load of PE*WMEM_DEPTH beats
s_axis_tvalid  in  1  stream beat valid
s_axis_tready  out  1  loader ready for a beat
s_axis_tdata  in  SIMD*TW  weight word
s_axis_tlast  in  1  marks the final beat of the load
wmem_we  out  PE  one-hot bank write enable
wmem_waddr  out  WMEM_ADDR_BW  bank write address
wmem_wdata  out  SIMD*TW  bank write data
busy  out  1  high while in LOAD
done  out  1  one-cycle pulse at load completion
err_len  out  1  sticky; tlast position mismatch in the current/last load

Behaviour:
- Clock: single clock aclk. Reset is synchronous and active-low (aresetn), sampled on the rising edge of aclk.
- Reset values: state=IDLE; pe_cnt=0; addr_cnt=0.
- All outputs 0 under reset: s_axis_tready, wmem_we, wmem_waddr, wmem_wdata, busy, done, err_len.
- State machine IDLE -> LOAD -> DONE -> IDLE.
- IDLE:
  - tready=0; start=1 -> LOAD.
  - On start: clear pe_cnt, addr_cnt and err_len.
- LOAD:
  - busy=1 and tready=1. Purely combinational from state; no backpressure from the memories.
  - A beat is accepted when tvalid&tready.
  - Per accepted beat: register wdata<=tdata, waddr<=addr_cnt, we<=(1<<pe_cnt), for exactly one cycle.
  - Write latency: beat accepted at edge N drives the write strobe during cycle N+1. we=0 in all other cycles.
  - Counter update: pe_cnt increments; at PE-1 it wraps to 0 and addr_cnt increments.
  - Final beat = beat index PE*WMEM_DEPTH-1 (pe_cnt=PE-1, addr_cnt=WMEM_DEPTH-1).
  - Final beat accepted -> DONE. If its tlast=0, set err_len.
  - Early tlast (tlast=1 on a non-final beat): the beat is still written, err_len set, -> DONE. Remaining addresses are left unwritten.
  - tvalid=0: counters hold. No timeout.
  - start asserted during LOAD or DONE is ignored.
- DONE:
  - One cycle only; done=1, coincident with the final write strobe. tready=0, busy=0.
  - -> IDLE.
- err_len holds until the next accepted start or reset.
- Reset mid-load: all state returns to reset values on the next edge and no further writes are issued. A pending write strobe registered in the reset cycle is suppressed.
- Widths:
  - wdata passes through unmodified with no sign handling.
  - addr_cnt is WMEM_ADDR_BW wide and never exceeds WMEM_DEPTH-1.
  - pe_cnt is clog2(PE) bits wide (min 1).
- PE=1: we is always bit 0, and addr_cnt increments on every beat.

Test Plan:
Defaults (SIMD=2, TW=1, PE=2, WMEM_DEPTH=4), 8 beats of tdata 0..3 repeating, tvalid always 1, tlast on beat 7 -> we sequence 01,10,01,10,... with waddr 0,0,1,1,2,2,3,3; done pulses once in the cycle of the 8th strobe; err_len=0; tready drops the cycle after the last beat.
Same stream with tvalid toggling 1,0,1,0 -> identical write sequence; no strobe in gap cycles; counters hold.
tlast on beat 4 (pe=0, addr=2) -> 5 writes issued, done pulses after the 5th, err_len=1; a subsequent start clears err_len.
8 beats with no tlast -> full 8 writes, done pulses, err_len=1.
aresetn=0 for one cycle after beat 3 -> no strobes afterwards, busy=0, tready=0; a new start and 8 beats load from addr 0, pe 0.
start pulses during LOAD -> ignored; counters continue without restarting; exactly one done pulse.
